intf_bank: RTL and testbench
============================

Name: intf_bank

Overview:
- Bank of NUM_LANES identical interface lanes.
- Each lane holds one single-bit state signal `val`, tagged with a configuration constant PARAM.
- Each lane answers a fixed-value function query that returns 5.
- Sits between a parent that owns the lane array and child blocks that read individual lanes (lane 0 is the common consumer).

Parameters:
- PARAM, 0, 32-bit configuration tag reported on param_out; no effect on logic.
- NUM_LANES, 2, number of lanes (1..16).
- IDX_W, 1, lane index width; must satisfy 2**IDX_W >= NUM_LANES.
- FUNC_VALUE, 5, 32-bit constant returned by the function query.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe for one lane's val.
- wr_idx  in  IDX_W  lane index to write.
- wr_data  in  1  value to store into val.
- wr_err  out  1  registered; 1 for one cycle after a write with an out-of-range index.
- rd_idx  in  IDX_W  lane index to read.
- rd_val  out  1  combinational val of lane rd_idx.
- rd_err  out  1  combinational; 1 when rd_idx >= NUM_LANES.
- vals  out  NUM_LANES  all lane vals, bit i = lane i.
- param_out  out  32  constant PARAM.
- func_req  in  1  function query request.
- func_idx  in  IDX_W  lane being queried.
- func_valid  out  1  registered response strobe.
- func_data  out  32  response data.

Behaviour:
- Reset (rst=1 at clk edge):
  - All lane vals = 0.
  - wr_err = 0, func_valid = 0, func_data = 0.
  - Reset overrides any simultaneous wr_en or func_req.
- Write:
  - wr_en=1 with wr_idx < NUM_LANES sets vals[wr_idx] = wr_data at the edge.
  - The new value is visible on vals and rd_val in the following cycle.
  - Other lanes are unchanged.
- Out-of-range write:
  - wr_en=1 with wr_idx >= NUM_LANES changes no state.
  - wr_err = 1 for exactly the next cycle; otherwise wr_err = 0.
- Read (purely combinational):
  - rd_val = vals[rd_idx] when in range.
  - rd_val = 0 and rd_err = 1 when rd_idx >= NUM_LANES.
- Read/write to the same lane in the same cycle: rd_val shows the old value (no write-through bypass).
- Function query:
  - func_req=1 at edge N gives func_valid = 1 at N+1.
  - In-range func_idx: func_data = FUNC_VALUE.
  - Out-of-range func_idx: func_data = 0.
  - Back-to-back requests give back-to-back responses; no stall, no ready signal.
  - func_data holds its last value when func_valid = 0.
- Constant outputs: param_out = PARAM at all times, including during reset.
- Width rules:
  - wr_data and val are 1 bit.
  - FUNC_VALUE and PARAM are truncated or zero-extended to 32 bits.

Optional Feature:
- Macro: INTF_BANK_TOGGLE_CNT_EN.
- When defined:
  - Adds output tog_cnt (16 bits, registered) counting writes whose wr_data differs from the addressed lane's current val (real toggles).
  - Counter saturates at 16'hFFFF.
  - Counter resets to 0 on rst.
  - Out-of-range writes are not counted.
- When undefined: port tog_cnt is absent and no counter logic is built.

Test Plan:
- Reset check: assert rst 2 cycles with wr_en=1, wr_data=1 -> vals=2'b00, func_valid=0, wr_err=0 after release; param_out=1 with PARAM=1.
- Lane write/read: write lane 1 <= 1 -> next cycle vals=2'b10; rd_idx=1 gives rd_val=1, rd_idx=0 gives rd_val=0; then write lane 0 <= 1 -> vals=2'b11.
- Same-cycle read/write: rd_idx=0 while writing lane 0 <= 0 from 1 -> rd_val=1 that cycle, 0 the next.
- Function query: func_req=1, func_idx=0 for 3 consecutive cycles -> func_valid=1 for 3 cycles each with func_data=5; drop func_req -> func_valid=0, func_data stays 5.
- Out-of-range (NUM_LANES=3, IDX_W=2): write idx 3 -> vals unchanged, wr_err=1 one cycle; rd_idx=3 gives rd_val=0, rd_err=1; func_idx=3 gives func_valid=1, func_data=0.
- With INTF_BANK_TOGGLE_CNT_EN: write lane 0 with 1,1,0,0,1 from reset -> tog_cnt=3.

Source files
------------

// File: rtl/intf_bank.sv
// intf_bank: NUM_LANES single-bit lanes with indexed write/read and a fixed-value function query.
// Optional macro INTF_BANK_TOGGLE_CNT_EN adds the registered tog_cnt output.

module intf_bank_lane (
    input  logic clk,
    input  logic rst,
    input  logic we_i,
    input  logic wdata_i,
    output logic val_o
);
    logic val_q, val_d;

    always_comb begin
        val_d = val_q;
        if (we_i) val_d = wdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst) val_q <= 1'b0;
        else     val_q <= val_d;
    end

    assign val_o = val_q;
endmodule

module intf_bank #(
    parameter logic [31:0] PARAM      = 32'd0,
    parameter int unsigned NUM_LANES  = 2,
    parameter int unsigned IDX_W      = 1,
    parameter logic [31:0] FUNC_VALUE = 32'd5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic                 wr_data,
    output logic                 wr_err,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_val,
    output logic                 rd_err,
    output logic [NUM_LANES-1:0] vals,
    output logic [31:0]          param_out,
    input  logic                 func_req,
    input  logic [IDX_W-1:0]     func_idx,
    output logic                 func_valid,
    output logic [31:0]          func_data
`ifdef INTF_BANK_TOGGLE_CNT_EN
    ,
    output logic [15:0]          tog_cnt
`endif
);
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } func_rsp_t;

    logic                 wr_in_range, rd_in_range, func_in_range;
    logic [NUM_LANES-1:0] lane_we;
    logic                 wr_err_q, wr_err_d;
    func_rsp_t            rsp_q, rsp_d;

    assign wr_in_range   = 32'(wr_idx)   < NUM_LANES;
    assign rd_in_range   = 32'(rd_idx)   < NUM_LANES;
    assign func_in_range = 32'(func_idx) < NUM_LANES;

    // Per-lane decode; an out-of-range index simply matches no lane.
    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            assign lane_we[g] = wr_en && (wr_idx == IDX_W'(g));
            intf_bank_lane u_lane (
                .clk     (clk),
                .rst     (rst),
                .we_i    (lane_we[g]),
                .wdata_i (wr_data),
                .val_o   (vals[g])
            );
        end
    endgenerate

    // Read mux built as a match loop so no index can ever fall outside vals.
    always_comb begin
        rd_val = 1'b0;
        for (int i = 0; i < NUM_LANES; i++)
            if (rd_idx == IDX_W'(i)) rd_val = vals[i];
    end
    assign rd_err = !rd_in_range;

    always_comb begin
        wr_err_d = wr_en && !wr_in_range;
        rsp_d    = rsp_q;
        rsp_d.valid = func_req;
        if (func_req) rsp_d.data = func_in_range ? FUNC_VALUE : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_q <= 1'b0;
            rsp_q    <= '0;
        end else begin
            wr_err_q <= wr_err_d;
            rsp_q    <= rsp_d;
        end
    end

    assign wr_err     = wr_err_q;
    assign func_valid = rsp_q.valid;
    assign func_data  = rsp_q.data;
    assign param_out  = PARAM;

`ifdef INTF_BANK_TOGGLE_CNT_EN
    logic        cur_wr_val;
    logic [15:0] tog_cnt_q, tog_cnt_d;

    always_comb begin
        cur_wr_val = 1'b0;
        for (int i = 0; i < NUM_LANES; i++)
            if (wr_idx == IDX_W'(i)) cur_wr_val = vals[i];
    end

    // Only real toggles count, and the counter sticks at all-ones.
    always_comb begin
        tog_cnt_d = tog_cnt_q;
        if (wr_en && wr_in_range && (wr_data != cur_wr_val) && (tog_cnt_q != 16'hFFFF))
            tog_cnt_d = tog_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) tog_cnt_q <= 16'd0;
        else     tog_cnt_q <= tog_cnt_d;
    end

    assign tog_cnt = tog_cnt_q;
`endif
endmodule

// File: tb/tb_intf_bank.sv
// Randomised + directed bench for intf_bank against a queue/array level behavioural model.
module tb_intf_bank;
    localparam int unsigned N  = 3;
    localparam int unsigned IW = 2;
    localparam logic [31:0] PV = 32'd1;
    localparam logic [31:0] FV = 32'd5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_idx = '0;
    logic          wr_data = 1'b0;
    logic          wr_err;
    logic [IW-1:0] rd_idx = '0;
    logic          rd_val, rd_err;
    logic [N-1:0]  vals;
    logic [31:0]   param_out;
    logic          func_req = 1'b0;
    logic [IW-1:0] func_idx = '0;
    logic          func_valid;
    logic [31:0]   func_data;
`ifdef INTF_BANK_TOGGLE_CNT_EN
    logic [15:0]   tog_cnt;
`endif

    int checks = 0;
    int errors = 0;

    intf_bank #(.PARAM(PV), .NUM_LANES(N), .IDX_W(IW), .FUNC_VALUE(FV)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .wr_err(wr_err), .rd_idx(rd_idx), .rd_val(rd_val), .rd_err(rd_err),
        .vals(vals), .param_out(param_out), .func_req(func_req), .func_idx(func_idx),
        .func_valid(func_valid), .func_data(func_data)
`ifdef INTF_BANK_TOGGLE_CNT_EN
        , .tog_cnt(tog_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: lane array plus last-response registers.
    bit          m_val [N];
    bit          m_wr_err = 0, m_fv = 0, m_ok = 0;
    int unsigned m_fd = 0, m_tog = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) m_val[i] <= 1'b0;
            m_wr_err <= 0; m_fv <= 0; m_fd <= 0; m_tog <= 0; m_ok <= 1;
        end else begin
            m_wr_err <= wr_en && (int'(wr_idx) >= N);
            if (wr_en && int'(wr_idx) < N) begin
                if (m_val[wr_idx] != wr_data && m_tog < 65535) m_tog <= m_tog + 1;
                m_val[wr_idx] <= wr_data;
            end
            m_fv <= func_req;
            if (func_req) m_fd <= (int'(func_idx) < N) ? FV : 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [N-1:0] ev;
        if (m_ok) begin
            for (int i = 0; i < N; i++) ev[i] = m_val[i];
            chk("m_vals", 32'(vals), 32'(ev));
            chk("m_rd_val", 32'(rd_val), (int'(rd_idx) < N) ? 32'(m_val[rd_idx]) : 32'd0);
            chk("m_rd_err", 32'(rd_err), 32'(int'(rd_idx) >= N));
            chk("m_wr_err", 32'(wr_err), 32'(m_wr_err));
            chk("m_func_valid", 32'(func_valid), 32'(m_fv));
            chk("m_func_data", func_data, m_fd);
            chk("m_param", param_out, PV);
`ifdef INTF_BANK_TOGGLE_CNT_EN
            chk("m_tog_cnt", 32'(tog_cnt), m_tog);
`endif
        end
    end

    // Inputs change shortly after a rising edge; returns at the following falling edge.
    task automatic step(input bit r, input bit we, input int wi, input bit wd,
                        input int ri, input bit fr, input int fi);
        @(posedge clk); #2;
        rst = r; wr_en = we; wr_idx = IW'(wi); wr_data = wd;
        rd_idx = IW'(ri); func_req = fr; func_idx = IW'(fi);
        @(negedge clk);
    endtask

    task automatic idle(input int ri);
        step(0, 0, 0, 0, ri, 0, 0);
    endtask

    initial begin
        chk("param_pre_reset", param_out, 32'd1);
        step(1, 1, 0, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0, 1, 0);
        chk("param_in_reset", param_out, 32'd1);
        idle(0);
        chk("rst_vals", 32'(vals), 32'd0);
        chk("rst_fv", 32'(func_valid), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);
        chk("rst_fd", func_data, 32'd0);

        step(0, 1, 1, 1, 0, 0, 0);
        idle(1);
        chk("wr1_vals", 32'(vals), 32'b010);
        chk("wr1_rd1", 32'(rd_val), 32'd1);
        idle(0);
        chk("wr1_rd0", 32'(rd_val), 32'd0);
        step(0, 1, 0, 1, 0, 0, 0);
        idle(0);
        chk("wr0_vals", 32'(vals), 32'b011);

        step(0, 1, 0, 0, 0, 0, 0);
        chk("rw_same_old", 32'(rd_val), 32'd1);
        idle(0);
        chk("rw_same_new", 32'(rd_val), 32'd0);

        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("fq_v1", 32'(func_valid), 32'd1);
        chk("fq_d1", func_data, 32'd5);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("fq_v2", 32'(func_valid), 32'd1);
        idle(0);
        chk("fq_v3", 32'(func_valid), 32'd1);
        chk("fq_d3", func_data, 32'd5);
        idle(0);
        chk("fq_drop_v", 32'(func_valid), 32'd0);
        chk("fq_hold_d", func_data, 32'd5);

        step(0, 1, 3, 1, 3, 1, 3);
        chk("oor_rd_val", 32'(rd_val), 32'd0);
        chk("oor_rd_err", 32'(rd_err), 32'd1);
        idle(0);
        chk("oor_wr_err", 32'(wr_err), 32'd1);
        chk("oor_vals", 32'(vals), 32'b010);
        chk("oor_fv", 32'(func_valid), 32'd1);
        chk("oor_fd", func_data, 32'd0);
        idle(0);
        chk("oor_wr_err_clr", 32'(wr_err), 32'd0);

`ifdef INTF_BANK_TOGGLE_CNT_EN
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0);
        idle(0);
        chk("tog_cnt_seq", 32'(tog_cnt), 32'd3);
`endif

        for (int k = 0; k < 3000; k++)
            step(($urandom_range(0, 59) == 0), $urandom_range(0, 1), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                 $urandom_range(0, 3));
        idle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
